// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle; sign handled by magnitude in, correction out.
module mdu_hilo #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] mt_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic                is_div;
   logic                neg_q;
   logic                neg_r;
   logic                div0;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W-1:0]   acc_hi;
   logic [DATA_W-1:0]   acc_lo;

   logic                sgn;
   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag_n;
   logic [DATA_W-1:0]   b_mag_n;
   logic [DATA_W-1:0]   addend;
   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     diff;
   logic                qbit;
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_neg;

   assign sgn     = ~op[0];
   assign a_neg   = sgn & rs_data[DATA_W-1];
   assign b_neg   = sgn & rt_data[DATA_W-1];
   assign a_mag_n = a_neg ? -rs_data : rs_data;
   assign b_mag_n = b_neg ? -rt_data : rt_data;

   // Multiply: add B into the upper half when the low bit is set, shift right.
   assign addend = acc_lo[0] ? b_mag : {DATA_W{1'b0}};
   assign sum    = {1'b0, acc_hi} + {1'b0, addend};

   // Divide: shift remainder left, keep the trial subtraction if non-negative.
   assign shifted = {acc_hi, acc_lo[DATA_W-1]};
   assign diff    = shifted - {1'b0, b_mag};
   assign qbit    = ~diff[DATA_W];

   assign prod     = {acc_hi, acc_lo};
   assign prod_neg = -prod;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         b_mag  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hi_we) hi <= mt_data;
               if (lo_we) lo <= mt_data;
               if (start) begin
                  state  <= CALC;
                  is_div <= op[1];
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  div0   <= (rt_data == '0);
                  b_mag  <= b_mag_n;
                  acc_hi <= '0;
                  acc_lo <= a_mag_n;
                  cnt    <= '0;
               end
            end
            CALC: begin
               if (is_div) begin
                  acc_hi <= qbit ? diff[DATA_W-1:0]
                                 : shifted[DATA_W-1:0];
                  acc_lo <= {acc_lo[DATA_W-2:0], qbit};
               end else begin
                  acc_hi <= sum[DATA_W:1];
                  acc_lo <= {sum[0], acc_lo[DATA_W-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               // Divide by zero leaves the dividend in the remainder path.
               if (is_div) begin
                  hi <= neg_r ? -acc_hi : acc_hi;
                  lo <= div0  ? {DATA_W{1'b1}}
                              : (neg_q ? -acc_lo : acc_lo);
               end else begin
                  {hi, lo} <= neg_q ? prod_neg : prod;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: per-cycle compare against a behavioural model,
// plus literal checks for the directed cases.
module tb_mdu_hilo;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  rs_data;
   logic [W-1:0]  rt_data;
   logic          hi_we;
   logic          lo_we;
   logic [W-1:0]  mt_data;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   mdu_hilo #(.DATA_W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data),
      .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [63:0] calc(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
      longint          p;
      longint unsigned pu;
      int              q, r;
      case (o)
         2'b00: begin
            p = longint'(int'(a)) * longint'(int'(b));
            return p;
         end
         2'b01: begin
            pu = longint'({32'h0, a}) * longint'({32'h0, b});
            return pu;
         end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Model: remaining edges until the result lands; zero means idle.
   int           m_rem = 0;
   logic         m_done = 1'b0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [63:0]  m_res = '0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst) begin
         m_rem = 0;
         m_hi  = '0;
         m_lo  = '0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            {m_hi, m_lo} = m_res;
            m_done = 1'b1;
         end
      end else begin
         if (hi_we) m_hi = mt_data;
         if (lo_we) m_lo = mt_data;
         if (start) begin
            m_res = calc(op, rs_data, rt_data);
            m_rem = W + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("busy", 64'(busy), 64'(m_rem > 0));
         chk("done", 64'(done), 64'(m_done));
         chk("hi", 64'(hi), 64'(m_hi));
         chk("lo", 64'(lo), 64'(m_lo));
      end
   end

   task automatic launch(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(negedge clk);
      start   = 1'b0;
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   // Returns on the negedge where done is seen; counts busy cycles seen.
   task automatic wait_done(output int nbusy);
      bit ok = 1'b0;
      nbusy = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (busy === 1'b1) nbusy++;
         if (done === 1'b1) ok = 1'b1;
      end
      chk("done_timeout", 64'(ok), 64'd1);
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh,
                      input logic [31:0] el, input string nm);
      int nb;
      launch(o, a, b);
      wait_done(nb);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      int nb;
      int ndone;
      rst = 1'b1; start = 1'b0; op = '0;
      rs_data = '0; rt_data = '0;
      hi_we = 1'b0; lo_we = 1'b0; mt_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);

      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(nb);
      chk("multu_busy_cycles", 64'(nb), 64'd33);
      chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

      run(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
          "mult");
      run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
      run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
          "div_neg");
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000,
          "div_ovf");
      run(2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF,
          "divu_zero");
      run(2'b10, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF,
          "div_zero");

      launch(2'b01, 32'd3, 32'd5);
      repeat (8) @(negedge clk);
      start = 1'b1; op = 2'b10;
      rs_data = 32'd99; rt_data = 32'd4;
      hi_we = 1'b1; mt_data = 32'h0000_DEAD;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      wait_done(nb);
      chk("intf_hi", 64'(hi), 64'd0);
      chk("intf_lo", 64'(lo), 64'd15);
      launch(2'b01, 32'd6, 32'd7);
      chk("b2b_busy", 64'(busy), 64'd1);
      wait_done(nb);
      chk("b2b_lo", 64'(lo), 64'd42);

      launch(2'b10, 32'd1000, 32'd3);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_hi", 64'(hi), 64'd0);
      chk("mrst_lo", 64'(lo), 64'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("mrst_no_done", 64'(ndone), 64'd0);

      hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_hi", 64'(hi), 64'hA5A5_A5A5);
      chk("mt_lo", 64'(lo), 64'hA5A5_A5A5);

      for (int i = 0; i < 8000; i++) begin
         start   = ($urandom_range(0, 2) == 0);
         op      = 2'($urandom);
         rs_data = $urandom;
         rt_data = $urandom;
         case ($urandom_range(0, 7))
            0: rt_data = '0;
            1: begin rs_data = 32'h8000_0000; rt_data = '1; end
            2: rt_data = 32'($urandom_range(1, 9));
            3: rt_data = -32'($urandom_range(1, 9));
            default: ;
         endcase
         hi_we   = ($urandom_range(0, 7) == 0);
         lo_we   = ($urandom_range(0, 7) == 0);
         mt_data = $urandom;
         rst     = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      repeat (40) @(negedge clk);

      en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
